// File: rtl/mc_main_fsm.sv
// Main control FSM for the multicycle RV32I core: sequences fetch, decode,
// execute, memory and writeback over the shared datapath.
module mc_main_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCUpdate,
  output logic       Branch,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  state_t state_q, state_d;

  logic       req_s, adr_s, irw_s, pcu_s, br_s, rw_s, mw_s, ill_s;
  logic [1:0] rsrc_s, srca_s, srcb_s, aluop_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    req_s   = 1'b0;
    adr_s   = 1'b0;
    irw_s   = 1'b0;
    pcu_s   = 1'b0;
    br_s    = 1'b0;
    rw_s    = 1'b0;
    mw_s    = 1'b0;
    ill_s   = 1'b0;
    rsrc_s  = 2'b00;
    srca_s  = 2'b00;
    srcb_s  = 2'b00;
    aluop_s = 2'b00;

    case (state_q)
      S_FETCH: begin
        req_s  = 1'b1;
        srcb_s = 2'b10;
        rsrc_s = 2'b10;
        irw_s  = mem_ready;
        pcu_s  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        srca_s = 2'b01;
        srcb_s = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        srca_s  = 2'b10;
        srcb_s  = 2'b01;
        state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        req_s = 1'b1;
        adr_s = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        rsrc_s  = 2'b01;
        rw_s    = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWRITE: begin
        req_s = 1'b1;
        adr_s = 1'b1;
        mw_s  = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        srca_s  = 2'b10;
        aluop_s = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        srca_s  = 2'b10;
        srcb_s  = 2'b01;
        aluop_s = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        rw_s    = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        srca_s  = 2'b10;
        aluop_s = 2'b01;
        br_s    = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        srca_s  = 2'b01;
        srcb_s  = 2'b10;
        pcu_s   = 1'b1;
        state_d = S_ALUWB;
      end
      S_ILLEGAL: begin
        ill_s   = 1'b1;
        state_d = S_ILLEGAL;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Outputs are forced quiet combinationally while reset is held, so an
  // abandoned instruction can never emit a write after rst_n falls.
  assign mem_req   = rst_n & req_s;
  assign AdrSrc    = rst_n & adr_s;
  assign IRWrite   = rst_n & irw_s;
  assign PCUpdate  = rst_n & pcu_s;
  assign Branch    = rst_n & br_s;
  assign RegWrite  = rst_n & rw_s;
  assign MemWrite  = rst_n & mw_s;
  assign illegal   = rst_n & ill_s;
  assign ResultSrc = {2{rst_n}} & rsrc_s;
  assign ALUSrcA   = {2{rst_n}} & srca_s;
  assign ALUSrcB   = {2{rst_n}} & srcb_s;
  assign ALUOp     = {2{rst_n}} & aluop_s;
  assign state     = state_q;

endmodule

// File: doc/mc_main_fsm.md
# mc_main_fsm

Main control state machine for the multicycle RV32I core. It sequences the shared datapath (single ALU, unified instruction/data memory port, instruction register, PC) through fetch, decode, execute, memory and writeback steps. It drives the datapath mux selects, register and memory write enables, and the 2-bit ALUOp consumed by the ALU decoder. Memory accesses use a ready handshake so that wait-stated memory stalls the sequence.

## Interface
Parameters: none.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- op  in  7  opcode field of the instruction register; must be stable from DECODE until the return to FETCH.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access requested this cycle.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result register.
- IRWrite  out  1  instruction register load.
- PCUpdate  out  1  unconditional PC load.
- Branch  out  1  conditional PC load; external logic ANDs it with zero.
- RegWrite  out  1  register file write.
- MemWrite  out  1  data memory write strobe.
- ResultSrc  out  2  result mux: 00 = ALUOut, 01 = read data, 10 = ALU result.
- ALUSrcA  out  2  A select: 00 = PC, 01 = OldPC, 10 = rs1 data.
- ALUSrcB  out  2  B select: 00 = rs2 data, 01 = immediate, 10 = constant 4.
- ALUOp  out  2  00 = add, 01 = sub/compare, 10 = decode funct fields.
- illegal  out  1  an unsupported opcode was trapped.
- state  out  4  current state, for debug.

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, ILLEGAL=11. Codes 12–15 go to FETCH on the next clock.
- All outputs are Moore outputs decoded from state, except the mem_ready-qualified strobes below. Any signal not listed for a state is 0.
- FETCH:
  - mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite = PCUpdate = mem_ready.
  - Stays in FETCH while mem_ready=0; moves to DECODE when mem_ready=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target precompute). Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - any other value → ILLEGAL
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to MEMREAD if op=0000011, otherwise MEMWRITE.
- MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00. Holds until mem_ready=1, then → MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 → FETCH.
- MEMWRITE: mem_req=1, AdrSrc=1, ResultSrc=00, MemWrite=mem_ready. Holds until mem_ready=1, then → FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10 → ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 → ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 → FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1 → FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 → ALUWB.
- ILLEGAL:
  - illegal=1, all other outputs 0, no memory request.
  - The state is sticky; only rst_n leaves it.

## Timing
- Reset:
  - rst_n=0 forces state=FETCH immediately, without waiting for clk.
  - While rst_n=0, all strobes (IRWrite, PCUpdate, RegWrite, MemWrite, Branch) are held 0, mem_req=0 and illegal=0.
  - Fetch begins on the first clk edge after rst_n deasserts.
- A reset mid-instruction abandons the instruction; no partial RegWrite or MemWrite is issued after rst_n falls.
- Cycle counts with zero-wait memory (mem_ready=1 throughout), measured FETCH to FETCH:

  | Instruction | Cycles |
  |---|---|
  | lw | 5 |
  | sw | 4 |
  | R-type | 4 |
  | I-type | 4 |
  | beq-class | 3 |
  | jal | 4 |

  Each wait cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Memory handshake:
  - mem_req stays high through the whole wait.
  - MemWrite, IRWrite and PCUpdate pulse for exactly one cycle, the mem_ready cycle, so each access produces exactly one write or load.
- mem_ready asserted outside FETCH/MEMREAD/MEMWRITE is ignored.

## Test plan
- Reset: drop rst_n asynchronously mid-cycle while in EXECR → state=0 before the next edge; all strobes 0; the first post-reset cycle has mem_req=1 and AdrSrc=0.
- lw, zero-wait, op=0000011: state sequence 0,1,2,3,4,0 (see Operation for the per-state outputs that mark it, including RegWrite=1 with ResultSrc=01 only in state 4).
- sw with 2 wait cycles, op=0100011, mem_ready low for 2 cycles in MEMWRITE:
  - state 5 held 3 cycles with mem_req=1.
  - MemWrite=1 only on the third cycle, then → 0.
- R-type, op=0110011: ALUOp=10 with ALUSrcB=00 in state 6, then RegWrite=1 in state 8. For op=0010011, ALUSrcB=01 in state 7.
- beq and jal:
  - op=1100011: state 9 with Branch=1, ALUOp=01, 3 cycles total.
  - op=1101111: state 10 with PCUpdate=1 and ALUSrcB=10, then state 8 with RegWrite=1.
- Illegal opcode, op=0000000 at DECODE:
  - state 11, illegal=1 and held for 10+ cycles with mem_req=0, regardless of mem_ready.
  - Asserting rst_n=0 clears illegal.
